// File: rtl/prio_arb_enc_if.sv
// Request/grant bundle for prio_arb_enc.
// Output handshake: out_valid/out_idx/out_oh are driven by the arbiter and
// stay stable until the consumer takes the slot. A transfer happens on a
// rising clk edge where out_valid & out_ready are both 1. out_ready may be
// asserted at any time and does not need to wait for out_valid.
interface prio_arb_enc_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic         en;
  logic         flush;
  logic [N-1:0] req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_oh;
  logic         pend_any;

  modport master (
    output en, flush, req, out_ready,
    input  out_valid, out_idx, out_oh, pend_any
  );

  modport slave (
    input  en, flush, req, out_ready,
    output out_valid, out_idx, out_oh, pend_any
  );
endinterface

// File: rtl/prio_arb_enc.sv
// Registered priority arbiter/encoder. Requests are captured sticky into a
// pending set; one winner per free output slot is chosen by a fixed
// highest-first, fixed lowest-first or round-robin policy and presented as
// index + one-hot on a valid/ready output.
module prio_arb_enc #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  prio_arb_enc_if.slave  bus
);
  localparam int W = $clog2(N);

  logic [N-1:0] pend;
  logic         out_valid_q;
  logic [W-1:0] out_idx_q;
  logic [N-1:0] out_oh_q;
  logic [W-1:0] rr_ptr;

  logic [N-1:0] cand;
  logic         free;
  logic         load;
  logic [W-1:0] win;
  logic [N-1:0] win_oh;
  logic [W:0]   scan;

  // Candidate set and load decision: a request already pending merges by OR.
  always_comb begin
    cand = pend | (bus.req & {N{bus.en}});
    free = !out_valid_q | bus.out_ready;
    load = bus.en & free & (|cand);
  end

  // Winner selection; later loop hits override earlier ones, so loop order
  // encodes the priority direction.
  always_comb begin
    win  = '0;
    scan = '0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++)
        if (cand[i]) win = W'(i);
    end else if (MODE == 1) begin
      for (int i = N - 1; i >= 0; i--)
        if (cand[i]) win = W'(i);
    end else begin
      // Scan offsets from far to near so the bit closest to rr_ptr wins.
      for (int k = N - 1; k >= 0; k--) begin
        scan = {1'b0, rr_ptr} + (W+1)'(k);
        if (scan >= (W+1)'(N)) scan = scan - (W+1)'(N);
        if (cand[scan[W-1:0]]) win = scan[W-1:0];
      end
    end
    win_oh = N'(1) << win;
  end

  // Pending set, output slot and round-robin pointer; flush overrides all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_oh_q    <= '0;
      rr_ptr      <= '0;
    end else if (bus.flush) begin
      pend        <= '0;
      out_valid_q <= 1'b0;
      out_oh_q    <= '0;
    end else if (load) begin
      pend        <= cand & ~win_oh;
      out_valid_q <= 1'b1;
      out_idx_q   <= win;
      out_oh_q    <= win_oh;
      rr_ptr      <= (win == W'(N - 1)) ? '0 : win + W'(1);
    end else begin
      pend <= cand;
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_oh_q    <= '0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_oh    = out_oh_q;
  assign bus.pend_any  = |pend;
endmodule

// File: tb/tb_prio_arb_enc.sv
// Bench for prio_arb_enc: four instances cover MODE0/1 at N=8, MODE2 at
// N=4 and MODE2 at non-power-of-two N=5. One instance is selected at a time;
// the others see idle inputs.
module tb_prio_arb_enc;
  logic clk;
  logic rst_n;

  int          sel;
  logic [7:0]  req_d;
  logic        en_d;
  logic        flush_d;
  logic        ready_d;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];   // {idx, one-hot}

  logic       m_valid;
  logic [7:0] m_idx;
  logic [7:0] m_oh;
  logic       m_pend;

  prio_arb_enc_if #(.N(8)) if0 ();
  prio_arb_enc_if #(.N(8)) if1 ();
  prio_arb_enc_if #(.N(4)) if2 ();
  prio_arb_enc_if #(.N(5)) if3 ();

  prio_arb_enc #(.N(8), .MODE(0)) u_m0  (.clk(clk), .rst_n(rst_n), .bus(if0));
  prio_arb_enc #(.N(8), .MODE(1)) u_m1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  prio_arb_enc #(.N(4), .MODE(2)) u_rr4 (.clk(clk), .rst_n(rst_n), .bus(if2));
  prio_arb_enc #(.N(5), .MODE(2)) u_rr5 (.clk(clk), .rst_n(rst_n), .bus(if3));

  assign if0.req = (sel == 0) ? req_d      : '0;
  assign if1.req = (sel == 1) ? req_d      : '0;
  assign if2.req = (sel == 2) ? req_d[3:0] : '0;
  assign if3.req = (sel == 3) ? req_d[4:0] : '0;
  assign if0.en  = (sel == 0) ? en_d : 1'b1;
  assign if1.en  = (sel == 1) ? en_d : 1'b1;
  assign if2.en  = (sel == 2) ? en_d : 1'b1;
  assign if3.en  = (sel == 3) ? en_d : 1'b1;
  assign if0.flush = (sel == 0) ? flush_d : 1'b0;
  assign if1.flush = (sel == 1) ? flush_d : 1'b0;
  assign if2.flush = (sel == 2) ? flush_d : 1'b0;
  assign if3.flush = (sel == 3) ? flush_d : 1'b0;
  assign if0.out_ready = (sel == 0) ? ready_d : 1'b1;
  assign if1.out_ready = (sel == 1) ? ready_d : 1'b1;
  assign if2.out_ready = (sel == 2) ? ready_d : 1'b1;
  assign if3.out_ready = (sel == 3) ? ready_d : 1'b1;

  // Outputs of the selected instance, zero-extended to 8 bits.
  always_comb begin
    m_valid = 1'b0;
    m_idx   = '0;
    m_oh    = '0;
    m_pend  = 1'b0;
    case (sel)
      0: begin m_valid = if0.out_valid; m_idx = 8'(if0.out_idx); m_oh = 8'(if0.out_oh); m_pend = if0.pend_any; end
      1: begin m_valid = if1.out_valid; m_idx = 8'(if1.out_idx); m_oh = 8'(if1.out_oh); m_pend = if1.pend_any; end
      2: begin m_valid = if2.out_valid; m_idx = 8'(if2.out_idx); m_oh = 8'(if2.out_oh); m_pend = if2.pend_any; end
      default: begin m_valid = if3.out_valid; m_idx = 8'(if3.out_idx); m_oh = 8'(if3.out_oh); m_pend = if3.pend_any; end
    endcase
  end

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int idx);
    logic [7:0] oh;
    oh = 8'd1 << idx;
    exp_q.push_back({8'(idx), oh});
  endtask

  // Pops one expected grant per accepted slot; called at a negedge.
  task automatic drain(input int exp_iters);
    int it;
    logic [15:0] e;
    it = 0;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      if (m_valid && ready_d) begin
        e = exp_q.pop_front();
        check_eq("idx", 32'(m_idx), 32'(e[15:8]));
        check_eq("oh", 32'(m_oh), 32'(e[7:0]));
      end
      it++;
      @(negedge clk);
    end
    check_eq("sb_left", 32'(exp_q.size()), 0);
    exp_q.delete();
    check_eq("grant_cycles", 32'(it), 32'(exp_iters));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_valid"}, 32'(m_valid), 0);
    check_eq({tag, "_pend"}, 32'(m_pend), 0);
  endtask

  task automatic do_flush();
    req_d = '0;
    flush_d = 1'b1;
    @(negedge clk);
    flush_d = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    int         cnt;
    rst_n = 1'b0; sel = 0; req_d = '0; en_d = 1'b1; flush_d = 1'b0; ready_d = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      check_eq("rst_valid", 32'(m_valid), 0);
      check_eq("rst_idx", 32'(m_idx), 0);
      check_eq("rst_oh", 32'(m_oh), 0);
      check_eq("rst_pend", 32'(m_pend), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sel = 0;
    @(negedge clk);

    // MODE0 one-shot 0x26: 5, 2, 1 back to back.
    req_d = 8'h26;
    push_exp(5); push_exp(2); push_exp(1);
    @(negedge clk);
    req_d = '0;
    check_eq("m0_latency", 32'(m_valid), 1);
    drain(3);
    check_idle("m0_end");

    // MODE1 same stimulus: 1, 2, 5.
    sel = 1;
    @(negedge clk);
    req_d = 8'h26;
    push_exp(1); push_exp(2); push_exp(5);
    @(negedge clk);
    req_d = '0;
    drain(3);
    check_idle("m1_end");

    // MODE1 random one-shot patterns: set bits come out lowest first.
    for (int r = 0; r < 4; r++) begin
      pat = 8'($urandom_range(1, 255));
      cnt = 0;
      for (int b = 0; b < 8; b++)
        if (pat[b]) begin push_exp(b); cnt++; end
      req_d = pat;
      @(negedge clk);
      req_d = '0;
      drain(cnt);
      check_idle("m1_rand");
    end

    // MODE2 N=4, all held: strict rotation through the wrap.
    sel = 2;
    @(negedge clk);
    req_d = 8'h0F;
    for (int i = 0; i < 8; i++) push_exp(i % 4);
    @(negedge clk);
    drain(8);
    do_flush();
    check_idle("rr4_flush");

    // Backpressure on MODE0 with 0x81.
    sel = 0;
    @(negedge clk);
    ready_d = 1'b0;
    req_d = 8'h81;
    @(negedge clk);
    req_d = '0;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", 32'(m_valid), 1);
      check_eq("bp_idx", 32'(m_idx), 7);
      check_eq("bp_oh", 32'(m_oh), 32'h80);
      check_eq("bp_pend", 32'(m_pend), 1);
      @(negedge clk);
    end
    push_exp(7); push_exp(0);
    ready_d = 1'b1;
    drain(2);
    check_idle("bp_end");

    // en=0 ignores req and holds pending; a held slot can still be accepted.
    ready_d = 1'b0;
    req_d = 8'hBC;
    @(negedge clk);
    req_d = 8'hFF;
    en_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("en0_valid", 32'(m_valid), 1);
      check_eq("en0_idx", 32'(m_idx), 7);
      check_eq("en0_pend", 32'(m_pend), 1);
    end
    ready_d = 1'b1;
    @(negedge clk);
    check_eq("en0_accept", 32'(m_valid), 0);
    check_eq("en0_pend_kept", 32'(m_pend), 1);
    en_d = 1'b1;
    req_d = '0;
    push_exp(5); push_exp(4); push_exp(3); push_exp(2);
    drain(5);
    check_idle("en0_end");

    // Flush with pend=0x3C and a held slot; req in the flush cycle is dropped.
    ready_d = 1'b0;
    req_d = 8'hBC;
    @(negedge clk);
    check_eq("fl_pre_valid", 32'(m_valid), 1);
    check_eq("fl_pre_pend", 32'(m_pend), 1);
    req_d = 8'hFF;
    flush_d = 1'b1;
    @(negedge clk);
    flush_d = 1'b0;
    req_d = '0;
    check_idle("fl");
    check_eq("fl_oh", 32'(m_oh), 0);
    check_eq("fl_idx_hold", 32'(m_idx), 7);
    @(negedge clk);
    check_idle("fl_after");
    ready_d = 1'b1;

    // Asynchronous reset between edges while a grant is held.
    ready_d = 1'b0;
    req_d = 8'h81;
    @(negedge clk);
    req_d = '0;
    check_eq("ar_pre_valid", 32'(m_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_valid", 32'(m_valid), 0);
    check_eq("ar_oh", 32'(m_oh), 0);
    check_eq("ar_pend", 32'(m_pend), 0);
    check_eq("ar_idx", 32'(m_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_d = 1'b1;
    @(negedge clk);
    check_idle("ar_after");

    // MODE2 N=5, all held: 0..4 then wrap to 0.
    sel = 3;
    @(negedge clk);
    req_d = 8'h1F;
    for (int i = 0; i < 7; i++) push_exp(i % 5);
    @(negedge clk);
    drain(7);
    do_flush();
    check_idle("rr5_flush");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
